// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 asynchronous serial receiver with mid-bit sampling and framing-error strobe
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       iRxPin,
    output logic [7:0] oData,
    output logic       oValid,
    output logic       oFrameErr,
    output logic       oBusy
);

    localparam int          HALF      = CLKS_PER_BIT / 2;
    localparam logic [31:0] HALF_LAST = 32'(HALF - 1);
    localparam logic [31:0] BIT_LAST  = 32'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t      state;
    logic        s1;
    logic        s2;
    logic        rxs;
    logic        rxs_d;
    logic [31:0] baud;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;

    assign rxs = s2;

    // Two-flop synchroniser on the raw pin plus one delayed copy for falling-edge detection.
    // Resetting to 1 matches the idle line, so a reset never fabricates a start edge.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            rxs_d <= 1'b1;
        end else begin
            s1    <= iRxPin;
            s2    <= s1;
            rxs_d <= s2;
        end
    end

    // Frame state machine: start qualification, data shifting, stop check and break hold-off.
    // The baud counter restarts on every state entry and every sample so each sample
    // point is measured from the previous one.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            baud      <= 32'd0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            oData     <= 8'h00;
            oValid    <= 1'b0;
            oFrameErr <= 1'b0;
            oBusy     <= 1'b0;
        end else begin
            oValid    <= 1'b0;
            oFrameErr <= 1'b0;
            baud      <= baud + 32'd1;
            case (state)
                IDLE: begin
                    // Only a genuine 1->0 transition starts a frame; a line already low is ignored.
                    if (rxs_d && !rxs) begin
                        state <= START;
                        baud  <= 32'd0;
                        oBusy <= 1'b1;
                    end
                end
                START: begin
                    if (baud == HALF_LAST) begin
                        baud <= 32'd0;
                        if (!rxs) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            // Line went back high before mid start bit: treat as noise.
                            state <= IDLE;
                            oBusy <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (baud == BIT_LAST) begin
                        baud  <= 32'd0;
                        shift <= {rxs, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (baud == BIT_LAST) begin
                        baud <= 32'd0;
                        if (rxs) begin
                            oData  <= shift;
                            oValid <= 1'b1;
                            state  <= IDLE;
                            oBusy  <= 1'b0;
                        end else begin
                            oFrameErr <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    // Hold off until the line recovers so a break is not read as 0x00 frames.
                    if (rxs) begin
                        state <= IDLE;
                        baud  <= 32'd0;
                        oBusy <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    baud  <= 32'd0;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a sample-time frame model
module tb_uart_rx;

    localparam int C = 16;
    localparam int H = 8;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       iRxPin = 1'b1;
    logic [7:0] oData;
    logic       oValid;
    logic       oFrameErr;
    logic       oBusy;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .iRxPin    (iRxPin),
        .oData     (oData),
        .oValid    (oValid),
        .oFrameErr (oFrameErr),
        .oBusy     (oBusy)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line value as seen after two clock stages, forced high while in reset.
    logic p1 = 1'b1;
    logic p2 = 1'b1;
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            p1 <= 1'b1;
            p2 <= 1'b1;
        end else begin
            p1 <= iRxPin;
            p2 <= p1;
        end
    end

    // Frame model: finds a start edge T0, then reads the line at T0+H and T0+H+k*C.
    logic       rxs_h [0:65535];
    int         mode = 0;
    int         t0 = 0;
    logic [7:0] e_data = 8'h00;
    logic       e_valid = 1'b0, e_ferr = 1'b0, e_busy = 1'b0;
    logic [7:0] n_data = 8'h00;
    logic       n_valid = 1'b0, n_ferr = 1'b0, n_busy = 1'b0;

    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    int         busy_cnt = 0;
    int         valid_cyc = 0;
    logic [7:0] rx_q [$];

    always @(negedge CLK) begin
        logic [7:0] b;
        cyc++;
        if (!RSTn) begin
            mode = 0;
            e_data = 8'h00; e_valid = 1'b0; e_ferr = 1'b0; e_busy = 1'b0;
            n_valid = 1'b0; n_ferr = 1'b0; n_busy = 1'b0;
            rxs_h[cyc] = 1'b1;
        end else begin
            e_valid = n_valid;
            e_ferr  = n_ferr;
            e_busy  = n_busy;
            if (n_valid) e_data = n_data;
            rxs_h[cyc] = p2;
            n_valid = 1'b0;
            n_ferr  = 1'b0;
            case (mode)
                0: if (rxs_h[cyc-1] == 1'b1 && rxs_h[cyc] == 1'b0) begin
                    t0 = cyc; mode = 1; n_busy = 1'b1;
                end
                1: begin
                    if (cyc == t0 + H && rxs_h[cyc] == 1'b1) begin
                        mode = 0; n_busy = 1'b0;
                    end else if (cyc == t0 + H + 9 * C) begin
                        for (int n = 0; n < 8; n++) b[n] = rxs_h[t0 + H + (n + 1) * C];
                        if (rxs_h[cyc]) begin
                            n_valid = 1'b1; n_data = b; mode = 0; n_busy = 1'b0;
                        end else begin
                            n_ferr = 1'b1; mode = 2;
                        end
                    end
                end
                default: if (rxs_h[cyc]) begin
                    mode = 0; n_busy = 1'b0;
                end
            endcase
        end
        check("oValid", oValid, e_valid);
        check("oFrameErr", oFrameErr, e_ferr);
        check("oBusy", oBusy, e_busy);
        check("oData", oData, e_data);
        if (oValid) begin
            valid_cnt++;
            valid_cyc = cyc;
            rx_q.push_back(oData);
        end
        if (oFrameErr) ferr_cnt++;
        if (oBusy) busy_cnt++;
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int bit_ns);
        iRxPin = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            iRxPin = d[i];
            #(bit_ns);
        end
        iRxPin = stop_bit;
        #(bit_ns);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    int   v0, f0, b0, start_cyc;
    logic [7:0] exp3 [3];

    initial begin
        exp3[0] = 8'h00; exp3[1] = 8'hFF; exp3[2] = 8'h3C;
        RSTn = 1'b0;
        iRxPin = 1'b1;
        repeat (5) @(posedge CLK);
        #1 RSTn = 1'b1;

        // 1: idle line after reset
        idle_cycles(200);
        check("t1_valid_cnt", valid_cnt, 0);
        check("t1_ferr_cnt", ferr_cnt, 0);
        check("t1_busy_cnt", busy_cnt, 0);
        check("t1_data", oData, 8'h00);

        // 2: single frame, pulse lands 3+8+144+1 cycles after the pin drop
        idle_cycles(1);
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1, 160);
        idle_cycles(20);
        check("t2_valid_cnt", valid_cnt, 1);
        check("t2_latency", valid_cyc - start_cyc, 156);
        check("t2_data", oData, 8'hA5);
        check("t2_ferr_cnt", ferr_cnt, 0);
        check("t2_busy", oBusy, 1'b0);

        // 3: back-to-back frames
        rx_q.delete();
        idle_cycles(5);
        send_frame(8'h00, 1'b1, 160);
        send_frame(8'hFF, 1'b1, 160);
        send_frame(8'h3C, 1'b1, 160);
        idle_cycles(20);
        check("t3_count", rx_q.size(), 3);
        for (int i = 0; i < rx_q.size() && i < 3; i++) check("t3_byte", rx_q[i], exp3[i]);

        // 4: 4-cycle glitch: busy for exactly the 8 cycles up to the half-bit check
        v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cnt;
        iRxPin = 1'b0;
        #40;
        iRxPin = 1'b1;
        idle_cycles(30);
        check("t4_no_valid", valid_cnt - v0, 0);
        check("t4_no_ferr", ferr_cnt - f0, 0);
        check("t4_busy_cycles", busy_cnt - b0, 8);
        check("t4_busy", oBusy, 1'b0);
        send_frame(8'h5A, 1'b1, 160);
        idle_cycles(20);
        check("t4_data", oData, 8'h5A);

        // 5: framing error then break, then a good frame
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h81, 1'b0, 160);
        #640;
        iRxPin = 1'b1;
        idle_cycles(30);
        check("t5_ferr_cnt", ferr_cnt - f0, 1);
        check("t5_no_valid", valid_cnt - v0, 0);
        check("t5_data_kept", oData, 8'h5A);
        send_frame(8'h42, 1'b1, 160);
        idle_cycles(20);
        check("t5_data", oData, 8'h42);
        check("t5_valid_cnt", valid_cnt - v0, 1);

        // 6: reset during data bit 3 of 0xC3
        v0 = valid_cnt; f0 = ferr_cnt;
        idle_cycles(3);
        iRxPin = 1'b0;
        #160;
        iRxPin = 1'b1; #160;
        iRxPin = 1'b1; #160;
        iRxPin = 1'b0; #160;
        iRxPin = 1'b0; #80;
        RSTn = 1'b0;
        #1;
        check("t6_rst_data", oData, 8'h00);
        check("t6_rst_busy", oBusy, 1'b0);
        check("t6_rst_valid", oValid, 1'b0);
        iRxPin = 1'b1;
        idle_cycles(3);
        RSTn = 1'b1;
        idle_cycles(200);
        check("t6_no_valid", valid_cnt - v0, 0);
        check("t6_no_ferr", ferr_cnt - f0, 0);
        send_frame(8'h99, 1'b1, 160);
        idle_cycles(20);
        check("t6_data_99", oData, 8'h99);
        send_frame(8'h55, 1'b1, 155);
        idle_cycles(20);
        check("t6_fast_55", oData, 8'h55);
        send_frame(8'hAA, 1'b1, 160);
        idle_cycles(20);
        check("t6_data_aa", oData, 8'hAA);
        send_frame(8'h55, 1'b1, 165);
        idle_cycles(20);
        check("t6_slow_55", oData, 8'h55);
        check("t6_valid_cnt", valid_cnt - v0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Asynchronous serial receiver, 8N1 format (1 start bit, 8 data bits LSB first, no parity, 1 stop bit). It is the receive companion to the team's baud-rate UART transmit logic and uses the same CLK-cycle baud divider, default 9600 bps from a 50 MHz CLK. The block synchronises the raw RX pin, qualifies the start bit, samples each bit at mid-period, and presents each received byte with a one-cycle valid strobe. A framing-error strobe flags a bad stop bit.

Parameters:
CLKS_PER_BIT, 5208, CLK cycles per bit period (50 MHz / 9600). Legal range is >= 4. HALF = CLKS_PER_BIT/2, using integer division.

Ports:
CLK  input  1  system clock; all logic is on the rising edge.
RSTn  input  1  asynchronous active-low reset; one clock domain only.
iRxPin  input  1  raw serial line, asynchronous to CLK; idles high.
oData  output  8  last correctly framed byte; holds until the next good frame.
oValid  output  1  one-cycle pulse when oData has just been updated.
oFrameErr  output  1  one-cycle pulse when the stop bit is sampled low.
oBusy  output  1  high in any state other than IDLE.

Behaviour:
- Synchroniser: iRxPin passes through 2 flops (s1, s2) to give rxs. A third flop holds rxs_d, the previous rxs.
- Reset values: s1, s2 and rxs_d are 1. Outputs are oData=8'h00, oValid=0, oFrameErr=0, oBusy=0. State is IDLE, bit counter 0, baud counter 0.
- Reset asserted mid-frame aborts the frame immediately. There is no output pulse for the aborted frame.
- Baud counter: 32-bit. It clears on every state entry and on every bit sample. Otherwise it increments by 1 per CLK.
- State machine has five states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: a start edge is rxs_d=1 and rxs=0. Call this cycle T0. On a start edge, go to START and clear the baud counter. A line that is already low when IDLE is entered is not an edge and does not start a frame.
- START: when the baud counter reaches HALF-1 (cycle T0+HALF), sample rxs.
  - If rxs=0: go to DATA, clear the baud counter and the bit index.
  - If rxs=1: treat as a glitch and return to IDLE with no pulse.
- DATA: when the baud counter reaches CLKS_PER_BIT-1, sample rxs into the shift register, LSB first (shift right, new bit into bit 7).
  - Data bit n (0..7) is sampled at T0+HALF+(n+1)*CLKS_PER_BIT.
  - After bit 7, go to STOP.
- STOP: sample at T0+HALF+9*CLKS_PER_BIT.
  - If rxs=1: load oData from the shift register, pulse oValid high for exactly the next cycle, and go to IDLE. The next frame's start edge can be detected from the following cycle.
  - If rxs=0: pulse oFrameErr high for exactly the next cycle, leave oData unchanged, and go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs=1, then go to IDLE. This prevents a break (line held low) from being received as a stream of 0x00 frames.
- oBusy is a registered decode of state != IDLE. It rises the cycle after T0.
- oValid and oFrameErr are never both high. Neither is ever high for more than 1 cycle per frame.
- Latency: oValid is high at cycle T0+HALF+9*CLKS_PER_BIT+1. T0 itself lags the pin edge by 2-3 CLK because of the synchroniser.
- Baud tolerance: a sender rate error of up to ±3% over a frame must be received correctly, since sampling is at mid-bit.

Test Plan:
Use CLKS_PER_BIT=16 (HALF=8) in all scenarios. The bench drives iRxPin with ideal 16-cycle bits.
1. Reset then idle: hold RSTn=0 for 5 cycles, release, keep iRxPin=1 for 200 cycles -> oData=8'h00, oValid, oFrameErr and oBusy stay 0 throughout.
2. Single frame 0xA5 -> oValid high for exactly 1 cycle at T0+8+144+1, oData=8'hA5, oFrameErr=0, oBusy back to 0 the cycle after.
3. Back-to-back frames 0x00, 0xFF, 0x3C with no idle gap between stop and next start -> three oValid pulses with oData 8'h00, 8'hFF, 8'h3C in order.
4. Glitch: 4-cycle low pulse on iRxPin -> START aborts at the half-bit check, no oValid, no oFrameErr, oBusy returns to 0. A following 0x5A frame is received correctly.
5. Framing error: send 0x81 with the stop bit low, then hold the line low for 64 more cycles, then high -> one oFrameErr pulse, oData keeps its previous value, no further frames while low. The next 0x42 frame gives oValid with oData=8'h42.
6. Reset mid-frame: assert RSTn during data bit 3 of 0xC3 -> outputs return to reset values immediately, no pulse. After release with the line high, a fresh 0x99 frame is received correctly. Also send 0x55 at 16±0.5 cycles/bit (±3%) and require oData=8'h55.
